cla_nibble_serial_adder_ctrl: RTL and testbench
===============================================

// Module: cla_nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer that time-shares one 4-bit carry_look_ahead_adder slice to add WIDTH-bit operands.
//  Processes one nibble per clock, LSB nibble first, and carries between nibbles in a register.
//  Valid/ready handshake on the operand side and on the result side.
//  Sits between an operand producer and a result consumer; area-cheap alternative to a wide CLA.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 4 (NIB = WIDTH/4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a, b, cin valid
//  in_ready   out  1      block can accept an operation (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to the least-significant nibble
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result, registered
//  cout       out  1      carry out of the most-significant nibble, registered
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, nibble counter=0, carry reg=0, sum=0, cout=0,
//    out_valid=0, busy=0, in_ready=1.
//  - FSM states:
//    - IDLE: in_valid&in_ready at an edge captures a, b and cin into the A/B shift regs and the
//      carry reg, sets cnt=0, goes to RUN. Operand changes after capture have no effect.
//    - RUN: each edge feeds A[3:0], B[3:0] and the carry reg to the slice. The slice sum is
//      shifted into the top of the sum reg (sum >> 4), carry reg <= slice cout, A/B shift right
//      by 4, cnt++. The edge with cnt==NIB-1 also loads cout and goes to DONE.
//    - DONE: out_valid=1. sum/cout are held stable until out_ready=1 at an edge, then IDLE.
//  - Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
//  - Throughput: one operation per NIB+2 cycles at best. No accept in DONE.
//  - Wrap: the result is modulo 2^WIDTH; overflow appears only on cout.
//  - WIDTH=4: RUN lasts one edge.
//  - in_valid while busy: ignored (in_ready=0). out_ready while not DONE: ignored.
//  - Reset mid-RUN/DONE: the operation is discarded and no out_valid is produced.
// CONFIGURATION
//  CLA_SEQ_SUB_EN defined:
//    - Adds input port op_sub (1 bit), sampled with the operands.
//    - op_sub=1: B is captured bit-inverted, the carry reg is loaded with 1 and cin is ignored.
//      The result is a-b mod 2^WIDTH; cout=1 means no borrow.
//    - op_sub=0: identical to add.
//  CLA_SEQ_SUB_EN undefined: op_sub is absent; add only.
// STRUCTURE
//  - Package cla_seq_pkg: state enum {IDLE, RUN, DONE}; NIBBLE_W=4 constant; function
//    nib_count(WIDTH) returning the counter width ($clog2 of NIB, minimum 1).
//  - One sub-module: the existing carry_look_ahead_adder (ports a, b, cin, sum, cout; 4-bit),
//    instantiated once as u_cla.
//  - Everything else is local: FSM, counter, shift regs, carry reg.
// TESTING (WIDTH=16 unless noted)
//  - a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 edges after accept,
//    busy high throughout.
//  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 nibbles).
//    Also a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0.
//  - out_ready held 0 for 10 cycles in DONE -> sum/cout stable, in_ready=0, and a new in_valid
//    is ignored. Then out_ready=1 -> IDLE, and the next op is accepted and correct.
//  - rst_n pulsed low after 2 RUN edges -> out_valid never rises, sum=0, cout=0; in_ready=1 on
//    release; the following op a=0x0101, b=0x1010 -> sum=0x1111.
//  - WIDTH=4: a=0xF, b=0x1, cin=1 -> sum=0x1, cout=1, out_valid 1 edge after accept.
//  - CLA_SEQ_SUB_EN: a=0x1000, b=0x0001, op_sub=1 -> sum=0x0FFF, cout=1.
//    a=0x0000, b=0x0001, op_sub=1 -> sum=0xFFFF, cout=0.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial CLA sequencer.
// Holds the FSM state enum, the slice width and the counter-width helper.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for WIDTH/4 nibbles; never narrower than one bit.
  function automatic int nib_count(input int width);
    int n;
    n = width / NIBBLE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// master = producer/consumer side, slave = adder side; op_sub exists only with CLA_SEQ_SUB_EN.
interface cla_nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
`ifdef CLA_SEQ_SUB_EN
    output op_sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
`ifdef CLA_SEQ_SUB_EN
    input  op_sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry look-ahead adder slice, purely combinational.
// Ports: a, b (4b), cin -> sum (4b), cout.
module carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit CLA slice, one nibble per clock, LSB first.
// Ports: clk, rst_n (async low), bus (slave: in/out valid-ready, a, b, cin, sum, cout, busy); CLA_SEQ_SUB_EN adds op_sub.
module cla_nibble_serial_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  cla_nibble_serial_adder_ctrl_if.slave bus
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = nib_count(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic [WIDTH-1:0]    sum_nx;
  logic                carry_q;
  logic                cout_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [NIBBLE_W-1:0] s_sum;
  logic                s_cout;
  logic [WIDTH-1:0]    b_in;
  logic                c_in;

`ifdef CLA_SEQ_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored.
  assign b_in = bus.op_sub ? ~bus.b : bus.b;
  assign c_in = bus.op_sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  carry_look_ahead_adder u_cla (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom.
  generate
    if (NIB == 1) begin : g_one
      assign sum_nx = s_sum;
    end else begin : g_many
      assign sum_nx = {s_sum, sum_q[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= b_in;
            carry_q    <= c_in;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_nx;
          carry_q <= s_cout;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_q      <= s_cout;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder_ctrl.sv
// Self-checking bench for the nibble-serial CLA adder (WIDTH=16 and WIDTH=4 instances).
// Reference model is plain integer addition; CLA_SEQ_SUB_EN enables the subtract test.
module tb_cla_nibble_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  cla_nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();
  cla_nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  cla_nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cla_nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic sub);
    if (sub) return {1'b0, av} + {1'b0, ~bv} + 17'd1;
    return {1'b0, av} + {1'b0, bv} + {16'd0, ci};
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sub, input bit rel,
                        output logic [15:0] s, output logic c,
                        output int lat, output bit busy_all);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.cin = ci;
`ifdef CLA_SEQ_SUB_EN
    bus.op_sub = sub;
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.cin = 1'($urandom);
    busy_all = (bus.busy === 1'b1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy !== 1'b1) busy_all = 0;
    end while (bus.out_valid !== 1'b1 && lat < 20);
    if (bus.out_valid !== 1'b1) lat = -1;
    s = bus.sum;
    c = bus.cout;
    if (rel) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    tests++;
    if (bus.sum !== 16'h0 || bus.cout !== 1'b0) begin
      fails++; $display("FAIL reset_sum got %h/%b want 0000/0", bus.sum, bus.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] av [3] = '{16'h1234, 16'hFFFF, 16'h000F};
    logic [15:0] bv [3] = '{16'h4321, 16'h0001, 16'h0000};
    logic        cv [3] = '{1'b0, 1'b0, 1'b1};
    logic [16:0] ev [3] = '{17'h05555, 17'h10000, 17'h00010};
    logic [15:0] s;
    logic        c;
    int          lat;
    bit          bz;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], 1'b0, 1, s, c, lat, bz);
      tests++;
      if ({c, s} !== ev[i]) begin
        fails++; $display("FAIL directed_%0d got %h want %h", i, {c, s}, ev[i]);
      end
      tests++;
      if (lat != 4) begin
        fails++; $display("FAIL latency_%0d got %0d want 4", i, lat);
      end
      tests++;
      if (!bz) begin
        fails++; $display("FAIL busy_%0d got low during op want high", i);
      end
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL release_%0d got rdy=%b ov=%b want 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] av, bv, s;
    logic        ci, c;
    logic [16:0] e;
    int          lat;
    bit          bz;
    for (int i = 0; i < 30; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      ci = 1'($urandom);
      e = model(av, bv, ci, 1'b0);
      run_op(av, bv, ci, 1'b0, 1, s, c, lat, bz);
      tests++;
      if ({c, s} !== e || lat != 4) begin
        fails++; $display("FAIL random_%0d got %h lat %0d want %h lat 4", i, {c, s}, lat, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] av, bv, s, s2;
    logic        c, c2;
    logic [16:0] e;
    int          lat;
    bit          bz, stable, rdy_low, ov_high;
    av = 16'($urandom);
    bv = 16'($urandom);
    e = model(av, bv, 1'b1, 1'b0);
    run_op(av, bv, 1'b1, 1'b0, 0, s, c, lat, bz);
    tests++;
    if ({c, s} !== e) begin
      fails++; $display("FAIL hold_result got %h want %h", {c, s}, e);
    end
    stable = 1; rdy_low = 1; ov_high = 1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(posedge clk);
      #1;
      if (bus.sum !== e[15:0] || bus.cout !== e[16]) stable = 0;
      if (bus.in_ready !== 1'b0) rdy_low = 0;
      if (bus.out_valid !== 1'b1) ov_high = 0;
    end
    bus.in_valid = 1'b0;
    tests++;
    if (!stable) begin
      fails++; $display("FAIL hold_stable got %h want %h", {bus.cout, bus.sum}, e);
    end
    tests++;
    if (!rdy_low) begin
      fails++; $display("FAIL hold_in_ready got high want low");
    end
    tests++;
    if (!ov_high) begin
      fails++; $display("FAIL hold_out_valid got low want high");
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL hold_release got ov=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    av = 16'($urandom);
    bv = 16'($urandom);
    e = model(av, bv, 1'b0, 1'b0);
    run_op(av, bv, 1'b0, 1'b0, 1, s2, c2, lat, bz);
    tests++;
    if ({c2, s2} !== e) begin
      fails++; $display("FAIL hold_next got %h want %h", {c2, s2}, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s;
    logic        c;
    int          lat;
    bit          bz, ov_seen;
    bus.in_valid = 1'b1;
    bus.a = 16'h7777;
    bus.b = 16'h8888;
    bus.cin = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.cout !== 1'b0) begin
      fails++; $display("FAIL midrst_state got ov=%b sum=%h cout=%b want 0/0000/0", bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL midrst_release got rdy=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
    ov_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ov_seen = 1;
    end
    tests++;
    if (ov_seen) begin
      fails++; $display("FAIL midrst_no_out got out_valid high want low");
    end
    run_op(16'h0101, 16'h1010, 1'b0, 1'b0, 1, s, c, lat, bz);
    tests++;
    if ({c, s} !== 17'h01111) begin
      fails++; $display("FAIL midrst_next got %h want 01111", {c, s});
    end
  endtask

  task automatic test_width4();
    logic [4:0] e;
    int         lat;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          e = 5'(av + bv + ci);
          bus4.in_valid = 1'b1;
          bus4.a = 4'(av);
          bus4.b = 4'(bv);
          bus4.cin = 1'(ci);
          @(posedge clk);
          #1;
          bus4.in_valid = 1'b0;
          lat = 0;
          do begin
            @(posedge clk);
            #1;
            lat++;
          end while (bus4.out_valid !== 1'b1 && lat < 10);
          tests++;
          if ({bus4.cout, bus4.sum} !== e || lat != 1) begin
            fails++; $display("FAIL w4_%0h_%0h_%0d got %h lat %0d want %h lat 1", av, bv, ci, {bus4.cout, bus4.sum}, lat, e);
          end
          bus4.out_ready = 1'b1;
          @(posedge clk);
          #1;
          bus4.out_ready = 1'b0;
        end
      end
    end
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    logic [15:0] s, av, bv;
    logic        c;
    logic [16:0] e;
    int          lat;
    bit          bz;
    run_op(16'h1000, 16'h0001, 1'b0, 1'b1, 1, s, c, lat, bz);
    tests++;
    if ({c, s} !== 17'h10FFF) begin
      fails++; $display("FAIL sub_a got %h want 10fff", {c, s});
    end
    run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 1, s, c, lat, bz);
    tests++;
    if ({c, s} !== 17'h0FFFF) begin
      fails++; $display("FAIL sub_b got %h want 0ffff", {c, s});
    end
    for (int i = 0; i < 10; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      e = model(av, bv, 1'b0, 1'b1);
      run_op(av, bv, 1'($urandom), 1'b1, 1, s, c, lat, bz);
      tests++;
      if ({c, s} !== e) begin
        fails++; $display("FAIL sub_rand_%0d got %h want %h", i, {c, s}, e);
      end
    end
    bus.op_sub = 1'b0;
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.cin = 1'b0;
    bus4.out_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    bus.op_sub = 1'b0;
    bus4.op_sub = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_width4();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
